bus_remap_pipe: RTL and testbench

//  Registered, run-time programmable bit remapper: each SINK_WIDTH output bit is

---
 rtl/bus_remap_pipe.sv | 125 ++++++++++++
 tb/tb_bus_remap_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_remap_pipe.sv
// rtl/bus_remap_pipe.sv - registered, run-time programmable bit remapper with handshaked config
// Optional out_parity output is built when REMAP_PARITY_EN is defined.
module bus_remap_pipe #(
    parameter int SRC_WIDTH  = 4,
    parameter int SINK_WIDTH = 4,
    localparam int IDX_W  = (SRC_WIDTH  > 1) ? $clog2(SRC_WIDTH)  : 1,
    localparam int SIDX_W = (SINK_WIDTH > 1) ? $clog2(SINK_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [SIDX_W-1:0]     cfg_sink_idx,
    input  logic [IDX_W-1:0]      cfg_src_idx,
    input  logic                  cfg_en,
    output logic                  cfg_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SRC_WIDTH-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SINK_WIDTH-1:0] out_data
`ifdef REMAP_PARITY_EN
   ,output logic                  out_parity
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        PROG  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SINK_WIDTH-1:0] map_en_q;
    logic [IDX_W-1:0]      map_src_q [SINK_WIDTH];
    logic [SINK_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q;
    logic                  cfg_err_q;
    logic                  accept;
    logic                  cfg_wr;
    logic                  cfg_bad;

    // The map is only rewritten once the output register is empty, so no word straddles two maps.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        case (state_q)
            RUN: begin
                in_ready = ~out_valid_q | out_ready;
                if (cfg_valid) state_d = DRAIN;
            end
            DRAIN: begin
                if (!out_valid_q || out_ready) state_d = PROG;
            end
            PROG: begin
                cfg_ready = 1'b1;
                state_d   = RUN;
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            in_ready  = 1'b0;
            cfg_ready = 1'b0;
        end
    end

    assign accept  = in_valid & in_ready;
    assign cfg_wr  = cfg_valid & cfg_ready;
    assign cfg_bad = (32'(cfg_sink_idx) >= 32'(SINK_WIDTH)) ||
                     (cfg_en && (32'(cfg_src_idx) >= 32'(SRC_WIDTH)));

    always_comb begin
        out_data_d = out_data_q;
        for (int i = 0; i < SINK_WIDTH; i++) begin
            if (map_en_q[i]) out_data_d[i] = in_data[map_src_q[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_err_q   <= 1'b0;
            map_en_q    <= '0;
            for (int i = 0; i < SINK_WIDTH; i++) map_src_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_wr & cfg_bad;
            if (accept) begin
                out_data_q  <= out_data_d;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            for (int i = 0; i < SINK_WIDTH; i++) begin
                if (cfg_wr && !cfg_bad && (32'(cfg_sink_idx) == 32'(i))) begin
                    map_en_q[i] <= cfg_en;
                    if (cfg_en) map_src_q[i] <= cfg_src_idx;
                end
            end
        end
    end

`ifdef REMAP_PARITY_EN
    logic out_parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_parity_q <= 1'b0;
        end else if (accept) begin
            out_parity_q <= ^out_data_d;
        end
    end

    assign out_parity = out_parity_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_bus_remap_pipe.sv
// tb/tb_bus_remap_pipe.sv - scoreboard bench for bus_remap_pipe (4x4 instance plus 3->6 range-check instance)
module tb_bus_remap_pipe;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       cfg_valid, cfg_ready, cfg_en, cfg_err;
    logic [1:0] cfg_sink_idx, cfg_src_idx;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_data, out_data;
`ifdef REMAP_PARITY_EN
    logic       out_parity;
`endif

    logic       b_cfg_valid, b_cfg_ready, b_cfg_en, b_cfg_err;
    logic [2:0] b_cfg_sink_idx;
    logic [1:0] b_cfg_src_idx;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0] b_in_data;
    logic [5:0] b_out_data;
`ifdef REMAP_PARITY_EN
    logic       b_out_parity;
`endif

    bus_remap_pipe #(.SRC_WIDTH(4), .SINK_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sink_idx(cfg_sink_idx),
        .cfg_src_idx(cfg_src_idx), .cfg_en(cfg_en), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef REMAP_PARITY_EN
       ,.out_parity(out_parity)
`endif
    );

    bus_remap_pipe #(.SRC_WIDTH(3), .SINK_WIDTH(6)) dut_b (
        .clk(clk), .rst(rst),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_sink_idx(b_cfg_sink_idx),
        .cfg_src_idx(b_cfg_src_idx), .cfg_en(b_cfg_en), .cfg_err(b_cfg_err),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef REMAP_PARITY_EN
       ,.out_parity(b_out_parity)
`endif
    );

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] m_en;
    logic [1:0] m_src [4];
    logic [3:0] m_out;
    logic [3:0] sb [$];
    bit         exp_err, hs, b_hs;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] remap(input logic [3:0] d);
        logic [3:0] r;
        r = m_out;
        for (int i = 0; i < 4; i++) if (m_en[i]) r[i] = d[m_src[i]];
        return r;
    endfunction

    task automatic step();
        logic [3:0] e;
        #1;
        chk("cfg_err", cfg_err, exp_err);
        exp_err = 1'b0;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                chk("sb_out", out_data, e);
`ifdef REMAP_PARITY_EN
                chk("sb_parity", out_parity, ^e);
`endif
            end
        end
        if (in_valid && in_ready) begin
            m_out = remap(in_data);
            sb.push_back(m_out);
        end
        hs = cfg_valid && cfg_ready;
        if (hs) begin
            if (int'(cfg_sink_idx) >= 4) exp_err = 1'b1;
            else begin
                m_en[cfg_sink_idx] = cfg_en;
                if (cfg_en) m_src[cfg_sink_idx] = cfg_src_idx;
            end
        end
        b_hs = b_cfg_valid && b_cfg_ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic prog(input int sink, input int src, input bit en);
        cfg_valid = 1'b1; cfg_sink_idx = 2'(sink); cfg_src_idx = 2'(src); cfg_en = en;
        hs = 1'b0;
        for (int k = 0; k < 20 && !hs; k++) step();
        chk("prog_handshake", hs, 1);
        cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] d);
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic prog_b(input int sink, input int src, input bit en, input bit err);
        b_cfg_valid = 1'b1; b_cfg_sink_idx = 3'(sink); b_cfg_src_idx = 2'(src); b_cfg_en = en;
        b_hs = 1'b0;
        for (int k = 0; k < 20 && !b_hs; k++) step();
        chk("b_prog_handshake", b_hs, 1);
        b_cfg_valid = 1'b0;
        chk("b_cfg_err_pulse", b_cfg_err, err);
        step();
        chk("b_cfg_err_clear", b_cfg_err, 0);
    endtask

    task automatic send_b(input logic [2:0] d);
        b_in_valid = 1'b1; b_in_data = d;
        step();
        b_in_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        cfg_valid = 0; cfg_sink_idx = 0; cfg_src_idx = 0; cfg_en = 0;
        in_valid = 0; in_data = 0; out_ready = 1;
        b_cfg_valid = 0; b_cfg_sink_idx = 0; b_cfg_src_idx = 0; b_cfg_en = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 1;
        m_en = '0; m_out = '0; exp_err = 0;
        for (int i = 0; i < 4; i++) m_src[i] = '0;
        @(negedge clk);
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 4'b0000);
        chk("rst_cfg_err", cfg_err, 0);
        send(4'hF);
        chk("unmapped_F", out_data, 4'b0000);

        prog(3, 3, 1);
        prog(2, 1, 1);
        send(4'b1010);
        chk("map_1010", out_data, 4'b1100);
`ifdef REMAP_PARITY_EN
        chk("parity_1100", out_parity, 0);
`endif
        send(4'b0101);
        chk("map_0101", out_data, 4'b0000);
        send(4'b1000);
        chk("map_1000", out_data, 4'b1000);
        chk("hold_bits_1_0", out_data[1:0], 2'b00);

        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'b1010;
        step();
        in_data = 4'b0101;
        step();
        chk("stall_in_ready_1", in_ready, 0);
        chk("stall_data_1", out_data, 4'b1100);
        step();
        chk("stall_in_ready_2", in_ready, 0);
        chk("stall_data_2", out_data, 4'b1100);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("stall_release", out_data, 4'b0000);

        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'b1010;
        cfg_valid = 1'b1; cfg_sink_idx = 2'd1; cfg_src_idx = 2'd3; cfg_en = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("drain_in_ready", in_ready, 0);
        chk("drain_cfg_ready", cfg_ready, 0);
        step();
        chk("drain_old_map", out_data, 4'b1100);
        out_ready = 1'b1;
        hs = 1'b0;
        for (int k = 0; k < 10 && !hs; k++) step();
        chk("drain_handshake", hs, 1);
        cfg_valid = 1'b0;
        send(4'b1010);
        chk("new_map_1010", out_data, 4'b1110);

        prog(3, 0, 0);
        send(4'b0000);
        chk("unassign_hold_1", out_data, 4'b1000);
        send(4'b1111);
        chk("unassign_hold_2", out_data, 4'b1110);

        for (int n = 0; n < 40; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 4'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        chk("sb_empty", 32'(sb.size()), 0);

        in_valid = 1'b1; in_data = 4'hF;
        step();
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        step();
        sb.delete();
        m_en = '0; m_out = '0;
        for (int i = 0; i < 4; i++) m_src[i] = '0;
        rst = 1'b0; out_ready = 1'b1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 4'b0000);
        send(4'hF);
        chk("midrst_map_cleared", out_data, 4'b0000);

        prog_b(5, 2, 1, 0);
        send_b(3'b100);
        chk("b_map_sink5", b_out_data, 6'b100000);
        prog_b(6, 0, 1, 1);
        prog_b(7, 0, 0, 1);
        prog_b(4, 3, 1, 1);
        send_b(3'b111);
        chk("b_map_unchanged", b_out_data, 6'b100000);
        prog_b(5, 3, 0, 0);
        send_b(3'b000);
        chk("b_unassign_hold", b_out_data, 6'b100000);

        chk("sb_final_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
